// File: rtl/music_sequencer.sv
// Multi-voice note sequencer. Each voice walks its own note table through an
// external combinational ROM port and drives a divider value to its tone
// generator. A shared tick prescaler paces the notes; voices that reach the
// end of their part wait in DONE until every voice is there, then all of them
// restart together from entry 0.
module music_sequencer #(
  parameter int VOICES      = 2,
  parameter int DIV_W       = 12,
  parameter int IDX_W       = 9,
  parameter int DUR_W       = 3,
  parameter int TICK_CYCLES = 8388608
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                enable,
  input  logic                                restart,
  input  logic [VOICES-1:0]                   mute,
  output logic [VOICES*IDX_W-1:0]             rom_addr,
  input  logic [VOICES*(1+DUR_W+DIV_W)-1:0]   rom_data,
  output logic [VOICES*DIV_W-1:0]             divider,
  output logic [VOICES-1:0]                   gate,
  output logic [VOICES-1:0]                   note_strobe,
  output logic [7:0]                          loop_count,
  output logic                                tick
);

  localparam int ENT_W = 1 + DUR_W + DIV_W;
  localparam int CNT_W = $clog2(TICK_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_CYCLES - 1);

  typedef enum logic [1:0] {LOAD, PLAY, DONE} state_t;

  state_t           state      [VOICES];
  state_t           state_nxt  [VOICES];
  logic [IDX_W-1:0] addr       [VOICES];
  logic [IDX_W-1:0] addr_nxt   [VOICES];
  logic [DIV_W-1:0] div_q      [VOICES];
  logic [DIV_W-1:0] div_nxt    [VOICES];
  logic [DUR_W-1:0] remain     [VOICES];
  logic [DUR_W-1:0] remain_nxt [VOICES];
  logic             last_q     [VOICES];
  logic             last_nxt   [VOICES];
  logic [VOICES-1:0] strobe_nxt;

  logic [DIV_W-1:0] ent_div  [VOICES];
  logic [DUR_W-1:0] ent_dur  [VOICES];
  logic             ent_last [VOICES];

  logic [CNT_W-1:0] cnt;
  logic             all_done;

  // Split each voice's ROM word into {last, dur, divider}.
  for (genvar v = 0; v < VOICES; v++) begin : g_entry
    assign ent_div[v]  = rom_data[v*ENT_W +: DIV_W];
    assign ent_dur[v]  = rom_data[v*ENT_W + DIV_W +: DUR_W];
    assign ent_last[v] = rom_data[v*ENT_W + DIV_W + DUR_W];
  end

  // Tick prescaler: wraps at TICK_CYCLES-1, frozen while enable is low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (restart) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
    end
  end

  assign tick = enable && (cnt == CNT_MAX);

  // Loop end is reached only when every voice sits in DONE simultaneously.
  always_comb begin
    all_done = 1'b1;
    for (int v = 0; v < VOICES; v++) begin
      if (state[v] != DONE) all_done = 1'b0;
    end
  end

  // State register: voice FSMs, addresses, visible dividers, strobes, loops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int v = 0; v < VOICES; v++) begin
        state[v] <= LOAD;
        addr[v]  <= '0;
        div_q[v] <= '0;
      end
      note_strobe <= '0;
      loop_count  <= '0;
    end else begin
      for (int v = 0; v < VOICES; v++) begin
        state[v] <= state_nxt[v];
        addr[v]  <= addr_nxt[v];
        div_q[v] <= div_nxt[v];
      end
      note_strobe <= strobe_nxt;
      if (!restart && all_done) loop_count <= loop_count + 1'b1;
    end
  end

  // Note bookkeeping registers; always rewritten by LOAD before first use.
  always_ff @(posedge clk) begin
    for (int v = 0; v < VOICES; v++) begin
      remain[v] <= remain_nxt[v];
      last_q[v] <= last_nxt[v];
    end
  end

  // Next-state logic: restart beats resync, resync beats per-voice ticks.
  always_comb begin
    for (int v = 0; v < VOICES; v++) begin
      state_nxt[v]  = state[v];
      addr_nxt[v]   = addr[v];
      div_nxt[v]    = div_q[v];
      remain_nxt[v] = remain[v];
      last_nxt[v]   = last_q[v];
      strobe_nxt[v] = (state[v] == LOAD) && !restart;
      if (restart || all_done) begin
        state_nxt[v] = LOAD;
        addr_nxt[v]  = '0;
      end else begin
        case (state[v])
          LOAD: begin
            div_nxt[v]    = ent_div[v];
            remain_nxt[v] = ent_dur[v];
            last_nxt[v]   = ent_last[v];
            state_nxt[v]  = PLAY;
          end
          PLAY: begin
            if (tick) begin
              if (remain[v] != '0) begin
                remain_nxt[v] = remain[v] - 1'b1;
              end else if (last_q[v]) begin
                state_nxt[v] = DONE;
                div_nxt[v]   = '0;
              end else begin
                addr_nxt[v]  = addr[v] + 1'b1;
                state_nxt[v] = LOAD;
              end
            end
          end
          DONE: begin
            state_nxt[v] = DONE;
          end
          default: begin
            state_nxt[v] = LOAD;
          end
        endcase
      end
    end
  end

  // Outputs: mute only masks what the tone generators see.
  always_comb begin
    rom_addr = '0;
    divider  = '0;
    gate     = '0;
    for (int v = 0; v < VOICES; v++) begin
      rom_addr[v*IDX_W +: IDX_W] = addr[v];
      divider[v*DIV_W +: DIV_W]  = mute[v] ? '0 : div_q[v];
      gate[v]                    = (div_q[v] != '0) && !mute[v];
    end
  end

endmodule
